// File: rtl/ex_pkg.sv
// Shared encodings for the execute-stage controller: opcodes, ALU operations,
// CCR bit positions and the opcode decoder used by ex_ctrl.
package ex_pkg;

    localparam int DATA_W  = 16;
    localparam int OPC_W   = 5;
    localparam int REG_W   = 3;
    localparam int ALUOP_W = 3;
    localparam int CCR_W   = 3;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OPC_W-1:0] OP_SETC = 5'h01;
    localparam logic [OPC_W-1:0] OP_CLRC = 5'h02;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'h03;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'h09;
    localparam logic [OPC_W-1:0] OP_LDM  = 5'h0C;
    localparam logic [OPC_W-1:0] OP_STD  = 5'h11;
    localparam logic [OPC_W-1:0] OP_RTI  = 5'h1B;

    localparam logic [ALUOP_W-1:0] ALU_NOP = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_LDM = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_STD = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 3'd4;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    typedef enum logic [2:0] {
        UPD_NONE,
        UPD_ADD,
        UPD_NOT,
        UPD_SETC,
        UPD_CLRC,
        UPD_RTI
    } ccr_upd_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        ccr_upd_e           upd;
        logic               wb;
        logic               mem_wr;
    } dec_t;

    // Unknown opcodes fall through to the NOP decode.
    function automatic dec_t decode(input logic [OPC_W-1:0] opc);
        dec_t d;
        d = '{ALU_NOP, UPD_NONE, 1'b0, 1'b0};
        case (opc)
            OP_SETC: d.upd = UPD_SETC;
            OP_CLRC: d.upd = UPD_CLRC;
            OP_RTI:  d.upd = UPD_RTI;
            OP_NOT:  d = '{ALU_NOT, UPD_NOT, 1'b1, 1'b0};
            OP_ADD:  d = '{ALU_ADD, UPD_ADD, 1'b1, 1'b0};
            OP_LDM:  d = '{ALU_LDM, UPD_NONE, 1'b1, 1'b0};
            OP_STD:  d = '{ALU_STD, UPD_NONE, 1'b0, 1'b1};
            default: d = '{ALU_NOP, UPD_NONE, 1'b0, 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Bundle of decode, ALU, memory-stage and interrupt signals around ex_ctrl.
// slave = the controller's view, master = the surrounding pipeline's view.
interface ex_if;
    import ex_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // valid must not depend on ready; the payload is held while valid && !ready.
    logic                 in_valid;
    logic                 in_ready;
    logic [OPC_W-1:0]     in_opcode;
    logic [DATA_W-1:0]    in_rs;
    logic [DATA_W-1:0]    in_rd;
    logic [DATA_W-1:0]    in_imm;
    logic [REG_W-1:0]     in_dst;

    logic [ALUOP_W-1:0]   alu_op;
    logic [DATA_W-1:0]    alu_rs;
    logic [DATA_W-1:0]    alu_rd;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_out;
    logic [CCR_W-1:0]     alu_ccr;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [REG_W-1:0]     out_dst;
    logic                 out_wb;
    logic                 out_mem_wr;

    logic [CCR_W-1:0]     ccr;
    logic                 int_save;
    logic                 flush;

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rd, in_imm, in_dst,
        output in_ready,
        output alu_op, alu_rs, alu_rd, alu_imm,
        input  alu_out, alu_ccr,
        output out_valid, out_data, out_dst, out_wb, out_mem_wr,
        input  out_ready,
        output ccr,
        input  int_save, flush
    );

    modport master (
        output in_valid, in_opcode, in_rs, in_rd, in_imm, in_dst,
        input  in_ready,
        input  alu_op, alu_rs, alu_rd, alu_imm,
        output alu_out, alu_ccr,
        input  out_valid, out_data, out_dst, out_wb, out_mem_wr,
        output out_ready,
        input  ccr,
        output int_save, flush
    );

endinterface

// File: rtl/ccr_unit.sv
// Architectural condition-code register and its interrupt shadow copy.
module ccr_unit
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  ccr_upd_e         upd,
    input  logic [CCR_W-1:0] alu_ccr,
    input  logic             int_save,
    output logic [CCR_W-1:0] ccr
);

    logic [CCR_W-1:0] ccr_q;
    logic [CCR_W-1:0] shadow_q;
    logic [CCR_W-1:0] ccr_next;

    always_comb begin
        ccr_next = ccr_q;
        if (commit) begin
            case (upd)
                UPD_ADD: ccr_next = alu_ccr;
                UPD_NOT: begin
                    ccr_next[CCR_Z] = alu_ccr[CCR_Z];
                    ccr_next[CCR_N] = alu_ccr[CCR_N];
                end
                UPD_SETC: ccr_next[CCR_C] = 1'b1;
                UPD_CLRC: ccr_next[CCR_C] = 1'b0;
                UPD_RTI:  ccr_next = shadow_q;
                default:  ccr_next = ccr_q;
            endcase
        end
    end

    // The shadow captures the post-commit value, so a same-edge RTI is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q    <= '0;
            shadow_q <= '0;
        end else begin
            ccr_q <= ccr_next;
            if (int_save) begin
                shadow_q <= ccr_next;
            end
        end
    end

    assign ccr = ccr_q;

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage controller: EX slot feeding the ALU, OUT slot toward memory,
// opcode decode and CCR commit sequencing.
module ex_ctrl
    import ex_pkg::*;
(
    input logic clk,
    input logic rst,
    ex_if.slave bus
);

    logic                ex_valid;
    logic [OPC_W-1:0]    ex_opc;
    logic [DATA_W-1:0]   ex_rs;
    logic [DATA_W-1:0]   ex_rd;
    logic [DATA_W-1:0]   ex_imm;
    logic [REG_W-1:0]    ex_dst;
    dec_t                ex_dec;

    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [REG_W-1:0]    out_dst_q;
    logic                out_wb_q;
    logic                out_mem_wr_q;

    logic                advance;
    logic                accept;
    logic                commit;

    assign ex_dec  = decode(ex_opc);
    assign advance = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !ex_valid || advance;
    // Flush suppresses both the accept and the commit on its edge.
    assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
    assign commit  = advance && ex_valid && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_opc   <= OP_NOP;
            ex_rs    <= '0;
            ex_rd    <= '0;
            ex_imm   <= '0;
            ex_dst   <= '0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_opc   <= bus.in_opcode;
            ex_rs    <= bus.in_rs;
            ex_rd    <= bus.in_rd;
            ex_imm   <= bus.in_imm;
            ex_dst   <= bus.in_dst;
        end else if (commit) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_dst_q    <= '0;
            out_wb_q     <= 1'b0;
            out_mem_wr_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (commit) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= bus.alu_out;
            out_dst_q    <= ex_dst;
            out_wb_q     <= ex_dec.wb;
            out_mem_wr_q <= ex_dec.mem_wr;
        end else if (advance) begin
            out_valid_q <= 1'b0;
        end
    end

    ccr_unit u_ccr (
        .clk      (clk),
        .rst      (rst),
        .commit   (commit),
        .upd      (ex_dec.upd),
        .alu_ccr  (bus.alu_ccr),
        .int_save (bus.int_save),
        .ccr      (bus.ccr)
    );

    assign bus.alu_op     = ex_dec.alu_op;
    assign bus.alu_rs     = ex_rs;
    assign bus.alu_rd     = ex_rd;
    assign bus.alu_imm    = ex_imm;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_dst    = out_dst_q;
    assign bus.out_wb     = out_wb_q;
    assign bus.out_mem_wr = out_mem_wr_q;

endmodule

// File: tb/tb_ex_ctrl.sv
// Bench for ex_ctrl: behavioural ALU, queue-based reference model of the two
// buffered ops and the CCR, directed scenarios followed by random traffic.
module tb_ex_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_if bus ();

    ex_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural ALU ----------------
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = 17'h0;
        case (bus.alu_op)
            3'd1: alu_sum = {1'b0, bus.alu_imm};
            3'd2: alu_sum = {1'b0, bus.alu_rs};
            3'd3: alu_sum = {1'b0, bus.alu_rs} + {1'b0, bus.alu_rd};
            3'd4: alu_sum = {1'b0, ~bus.alu_rs};
            default: alu_sum = 17'h0;
        endcase
        bus.alu_out = alu_sum[15:0];
        bus.alu_ccr = {alu_sum[16], alu_sum[15], alu_sum[15:0] == 16'h0};
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  opc;
        logic [15:0] rs;
        logic [15:0] rd;
        logic [15:0] imm;
        logic [2:0]  dst;
        bit          done;
        logic [15:0] data;
        logic        wb;
        logic        mw;
    } mop_t;

    mop_t       mq[$];
    logic [2:0] m_ccr;
    logic [2:0] m_sh;

    function automatic bit m_out_valid();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    function automatic bit m_ex_valid();
        return (mq.size() == 2) || (mq.size() == 1 && !mq[0].done);
    endfunction

    function automatic logic [2:0] exp_alu_op(input logic [4:0] o);
        case (o)
            5'h0C:   return 3'd1;
            5'h11:   return 3'd2;
            5'h09:   return 3'd3;
            5'h03:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic model_exec();
        logic [16:0] s;
        mq[0].data = 16'h0;
        mq[0].wb   = 1'b0;
        mq[0].mw   = 1'b0;
        case (mq[0].opc)
            5'h09: begin
                s = {1'b0, mq[0].rs} + {1'b0, mq[0].rd};
                mq[0].data = s[15:0];
                mq[0].wb   = 1'b1;
                m_ccr      = {s[16], s[15], s[15:0] == 16'h0};
            end
            5'h03: begin
                mq[0].data = ~mq[0].rs;
                mq[0].wb   = 1'b1;
                m_ccr      = {m_ccr[2], mq[0].data[15], mq[0].data == 16'h0};
            end
            5'h0C: begin
                mq[0].data = mq[0].imm;
                mq[0].wb   = 1'b1;
            end
            5'h11: begin
                mq[0].data = mq[0].rs;
                mq[0].mw   = 1'b1;
            end
            5'h01: m_ccr[2] = 1'b1;
            5'h02: m_ccr[2] = 1'b0;
            5'h1B: m_ccr = m_sh;
            default: ;
        endcase
        mq[0].done = 1'b1;
    endtask

    task automatic model_edge();
        bit   ov;
        bit   exv;
        bit   adv;
        bit   acc;
        mop_t n;
        if (rst) begin
            mq.delete();
            m_ccr = 3'b000;
            m_sh  = 3'b000;
        end else if (bus.flush) begin
            mq.delete();
            if (bus.int_save) m_sh = m_ccr;
        end else begin
            ov  = m_out_valid();
            exv = m_ex_valid();
            adv = !ov || bus.out_ready;
            acc = bus.in_valid && (!exv || adv);
            if (ov && bus.out_ready) mq.delete(0);
            if (exv && adv) model_exec();
            if (acc) begin
                n.opc  = bus.in_opcode;
                n.rs   = bus.in_rs;
                n.rd   = bus.in_rd;
                n.imm  = bus.in_imm;
                n.dst  = bus.in_dst;
                n.done = 1'b0;
                n.data = 16'h0;
                n.wb   = 1'b0;
                n.mw   = 1'b0;
                mq.push_back(n);
            end
            if (bus.int_save) m_sh = m_ccr;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare();
        bit ov;
        bit exv;
        ov  = m_out_valid();
        exv = m_ex_valid();
        chk("in_ready", 16'(bus.in_ready), 16'(!exv || !ov || bus.out_ready));
        chk("out_valid", 16'(bus.out_valid), 16'(ov));
        if (ov) begin
            chk("out_data", bus.out_data, mq[0].data);
            chk("out_dst", 16'(bus.out_dst), 16'(mq[0].dst));
            chk("out_wb", 16'(bus.out_wb), 16'(mq[0].wb));
            chk("out_mem_wr", 16'(bus.out_mem_wr), 16'(mq[0].mw));
        end
        if (exv) chk("alu_op", 16'(bus.alu_op), 16'(exp_alu_op(mq[mq.size()-1].opc)));
        chk("ccr", 16'(bus.ccr), 16'(m_ccr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [4:0] o, input logic [15:0] rs, input logic [15:0] rd,
                         input logic [15:0] imm, input logic [2:0] dst);
        bus.in_valid  = 1'b1;
        bus.in_opcode = o;
        bus.in_rs     = rs;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_dst    = dst;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    logic [4:0] opc_tab[8];

    initial begin
        opc_tab = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h09, 5'h0C, 5'h11, 5'h1B};
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_opcode = 5'h0; bus.in_rs = 16'h0; bus.in_rd = 16'h0;
        bus.in_imm = 16'h0; bus.in_dst = 3'h0; bus.out_ready = 1'b1;
        bus.int_save = 1'b0; bus.flush = 1'b0;
        m_ccr = 3'b000; m_sh = 3'b000;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_ccr", 16'(bus.ccr), 16'h0);
        chk("rst_in_ready", 16'(bus.in_ready), 16'h1);

        // ADD 0x7FFF + 1
        drive(5'h09, 16'h7FFF, 16'h0001, 16'h0, 3'd3); step();
        idle(); step();
        chk("add_data", bus.out_data, 16'h8000);
        chk("add_ccr", 16'(bus.ccr), 16'(3'b010));
        chk("add_wb", 16'(bus.out_wb), 16'h1);

        // ADD wrapping to zero, then LDM
        drive(5'h09, 16'hFFFF, 16'h0001, 16'h0, 3'd1); step();
        drive(5'h0C, 16'h0, 16'h0, 16'h1234, 3'd2); step();
        chk("add2_data", bus.out_data, 16'h0000);
        chk("add2_ccr", 16'(bus.ccr), 16'(3'b101));
        idle(); step();
        chk("ldm_data", bus.out_data, 16'h1234);
        chk("ldm_ccr", 16'(bus.ccr), 16'(3'b101));

        // SETC then NOT keeps carry
        drive(5'h01, 16'h0, 16'h0, 16'h0, 3'd0); step();
        drive(5'h03, 16'h0000, 16'h0, 16'h0, 3'd4); step();
        idle(); step();
        chk("not_data", bus.out_data, 16'hFFFF);
        chk("not_ccr", 16'(bus.ccr), 16'(3'b110));
        step();

        // four ops through a three-cycle stall
        drive(5'h0C, 16'h0, 16'h0, 16'hA001, 3'd1); step();
        bus.out_ready = 1'b0;
        drive(5'h0C, 16'h0, 16'h0, 16'hA002, 3'd2); step();
        chk("stall_in_ready", 16'(bus.in_ready), 16'h0);
        chk("stall_data0", bus.out_data, 16'hA001);
        drive(5'h0C, 16'h0, 16'h0, 16'hA003, 3'd3); step();
        chk("stall_hold1", bus.out_data, 16'hA001);
        step();
        chk("stall_hold2", bus.out_data, 16'hA001);
        bus.out_ready = 1'b1; step();
        chk("order_b", bus.out_data, 16'hA002);
        drive(5'h0C, 16'h0, 16'h0, 16'hA004, 3'd4); step();
        chk("order_c", bus.out_data, 16'hA003);
        idle(); step();
        chk("order_d", bus.out_data, 16'hA004);
        step();
        chk("drained", 16'(bus.out_valid), 16'h0);

        // interrupt shadow round trip
        drive(5'h09, 16'h7FFF, 16'h0001, 16'h0, 3'd1); step();
        idle(); step();
        chk("pre_save_ccr", 16'(bus.ccr), 16'(3'b010));
        bus.int_save = 1'b1; step();
        bus.int_save = 1'b0;
        drive(5'h09, 16'hFFFF, 16'h0001, 16'h0, 3'd1); step();
        idle(); step();
        chk("post_add_ccr", 16'(bus.ccr), 16'(3'b101));
        drive(5'h1B, 16'h0, 16'h0, 16'h0, 3'd0); step();
        idle(); step();
        chk("rti_ccr", 16'(bus.ccr), 16'(3'b010));
        chk("rti_wb", 16'(bus.out_wb), 16'h0);

        // flush with both slots full and a zero-setting ADD pending
        bus.out_ready = 1'b0;
        drive(5'h0C, 16'h0, 16'h0, 16'h5555, 3'd2); step();
        drive(5'h09, 16'hFFFF, 16'h0001, 16'h0, 3'd1); step();
        idle(); bus.flush = 1'b1; step();
        bus.flush = 1'b0;
        chk("flush_valid", 16'(bus.out_valid), 16'h0);
        chk("flush_ccr", 16'(bus.ccr), 16'(3'b010));
        bus.out_ready = 1'b1; step();
        chk("flush_after", 16'(bus.out_valid), 16'h0);

        // reset in the middle of a stall
        bus.int_save = 1'b1; step();
        bus.int_save = 1'b0; bus.out_ready = 1'b0;
        drive(5'h0C, 16'h0, 16'h0, 16'hBEEF, 3'd5); step();
        drive(5'h11, 16'h1111, 16'h0, 16'h0, 3'd6); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0;
        chk("rst2_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst2_out_data", bus.out_data, 16'h0);
        chk("rst2_out_dst", 16'(bus.out_dst), 16'h0);
        chk("rst2_out_wb", 16'(bus.out_wb), 16'h0);
        chk("rst2_mem_wr", 16'(bus.out_mem_wr), 16'h0);
        chk("rst2_ccr", 16'(bus.ccr), 16'h0);
        chk("rst2_in_ready", 16'(bus.in_ready), 16'h1);
        chk("rst2_alu_op", 16'(bus.alu_op), 16'h0);
        bus.out_ready = 1'b1;
        drive(5'h1B, 16'h0, 16'h0, 16'h0, 3'd0); step();
        idle(); step();
        chk("rst2_shadow", 16'(bus.ccr), 16'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) bus.in_opcode = opc_tab[$urandom_range(0, 7)];
            else                          bus.in_opcode = 5'($urandom_range(0, 31));
            bus.in_rs  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            bus.in_rd  = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
            bus.in_imm = 16'($urandom);
            bus.in_dst = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.int_save  = ($urandom_range(0, 9) == 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; bus.flush = 1'b0; bus.int_save = 1'b0; idle();
        bus.out_ready = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
